// File: rtl/i2s_stereo_tx.sv
`timescale 1ns/1ps
// i2s_stereo_tx
//   Philips I2S bus master transmitter. Generates SCLK (clk/2) and WS, and
//   serializes one stereo sample per frame: left word then right word, MSB
//   first, with the standard one-bit data delay after each WS transition.
//   tx_data is captured once per frame at the first bit slot; ready pulses
//   for one clk at that moment so the source can present the next sample.
//
// Ports
//   clk      in   system clock, all state updates on its rising edge
//   rst_n    in   asynchronous active-low reset
//   tx_data  in   [2*DWIDTH-1:DWIDTH] left word, [DWIDTH-1:0] right word
//   ready    out  one-clk pulse, tx_data has just been captured
//   SCLK     out  I2S bit clock (clk/2), registered
//   WS       out  word select, 0 = left, 1 = right, registered
//   SD       out  serial data, changes only when SCLK falls
module i2s_stereo_tx #(
  parameter int DWIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2*DWIDTH-1:0]   tx_data,
  output logic                  ready,
  output logic                  SCLK,
  output logic                  WS,
  output logic                  SD
);

  localparam int FW = 2 * DWIDTH;
  localparam int CW = (FW > 1) ? $clog2(FW) : 1;
  localparam logic [CW-1:0] CNT_LAST     = CW'(FW - 1);
  localparam logic [CW-1:0] CNT_LEFT_LSB = CW'(DWIDTH - 1);

  logic [CW-1:0] cnt, cnt_nxt;
  logic [FW-1:0] shreg, shreg_nxt;
  logic          sclk_nxt, ws_nxt, sd_nxt, ready_nxt;
  logic          fall;

  // SCLK is currently high, so this clk edge drives it low: the only edge
  // on which SD, WS and the bit counter may move.
  assign fall = SCLK;

  always_comb begin
    sclk_nxt  = ~SCLK;
    cnt_nxt   = cnt;
    shreg_nxt = shreg;
    sd_nxt    = SD;
    ws_nxt    = WS;
    ready_nxt = 1'b0;
    if (fall) begin
      cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
      if (cnt == '0) begin
        // The MSB goes straight onto SD, so keep the remaining bits
        // pre-shifted with the next one waiting at the top.
        shreg_nxt = tx_data << 1;
        sd_nxt    = tx_data[FW-1];
        ready_nxt = 1'b1;
      end else begin
        sd_nxt    = shreg[FW-1];
        shreg_nxt = shreg << 1;
      end
      // WS leads the data by one bit: it flips while the LSB of the
      // current word is still being driven.
      if (cnt == CNT_LEFT_LSB) begin
        ws_nxt = 1'b1;
      end else if (cnt == CNT_LAST) begin
        ws_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SCLK  <= 1'b0;
      WS    <= 1'b0;
      SD    <= 1'b0;
      ready <= 1'b0;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      SCLK  <= sclk_nxt;
      WS    <= ws_nxt;
      SD    <= sd_nxt;
      ready <= ready_nxt;
      cnt   <= cnt_nxt;
      shreg <= shreg_nxt;
    end
  end

endmodule

// File: tb/tb_i2s_stereo_tx.sv
`timescale 1ns/1ps
module tb_i2s_stereo_tx;

  localparam int DW = 8;
  localparam int FW = 2 * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [FW-1:0] tx_data = '0;
  logic          ready, SCLK, WS, SD;

  int total = 0;
  int bad   = 0;

  i2s_stereo_tx #(.DWIDTH(DW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .tx_data(tx_data),
    .ready  (ready),
    .SCLK   (SCLK),
    .WS     (WS),
    .SD     (SD)
  );

  always #5 clk = ~clk;

  // Receiver model: an independent I2S slave that samples SD on SCLK rising
  // edges and closes a word on the rising edge following each WS fall.
  logic [FW-1:0] rx_q[$];
  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] rx_sh;
  int            bit_idx;
  logic          prev_sclk, prev_ws, prev_ready;
  bit            pend, have_last;
  longint        cyc = 0;
  longint        last_rdy;
  int            ws_err = 0, rdy_width_err = 0, rdy_gap_err = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        bit_idx    = -1;
        pend       = 1'b0;
        have_last  = 1'b0;
        prev_sclk  = 1'b0;
        prev_ws    = 1'b0;
        prev_ready = 1'b0;
      end else begin
        if (ready) begin
          if (prev_ready) begin
            rdy_width_err++;
          end else begin
            if (have_last && (cyc - last_rdy) != 2 * FW) rdy_gap_err++;
            last_rdy  = cyc;
            have_last = 1'b1;
          end
        end
        if (prev_ws && !WS) pend = 1'b1;
        if (!prev_sclk && SCLK) begin
          if (bit_idx < 0) begin
            // first SCLK rise after reset precedes the first data bit
            bit_idx = 0;
          end else begin
            rx_sh = {rx_sh[FW-2:0], SD};
            // right channel bits are DW..FW-1; WS leads the data by one bit
            if (WS !== ((bit_idx >= DW - 1) && (bit_idx <= FW - 2))) ws_err++;
            bit_idx = (bit_idx + 1) % FW;
            if (pend) begin
              rx_q.push_back(rx_sh);
              pend = 1'b0;
            end
          end
        end
        prev_sclk  = SCLK;
        prev_ws    = WS;
        prev_ready = ready;
      end
    end
  end

  task automatic clear_state();
    rx_q.delete();
    exp_q.delete();
    ws_err        = 0;
    rdy_width_err = 0;
    rdy_gap_err   = 0;
  endtask

  // Asynchronous reset at whatever time it is called; released between edges.
  task automatic do_reset(input logic [FW-1:0] first);
    tx_data = first;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 clear_state();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4 * FW + 8; i++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rx(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < (n + 3) * 2 * FW; i++) begin
      if (rx_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
    end
    if (rx_q.size() >= n) ok = 1'b1;
  endtask

  // Present a fresh random sample after every ready; record what was captured.
  task automatic stream(input string name, input int n);
    bit ok;
    for (int i = 0; i < n; i++) begin
      wait_ready(ok);
      if (!ok) begin
        total++; bad++;
        $display("FAIL %s ready_timeout: sample %0d got no ready, required a pulse", name, i);
        return;
      end
      exp_q.push_back(tx_data);
      tx_data = FW'($urandom);
    end
  endtask

  task automatic check_words(input string name);
    bit ok;
    int n;
    n = exp_q.size();
    wait_rx(n, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s rx_count: got %0d words, required %0d", name, rx_q.size(), n);
      return;
    end
    for (int i = 0; i < n; i++) begin
      total++;
      if (rx_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL %s word%0d: got %h, required %h", name, i, rx_q[i], exp_q[i]);
      end
    end
    total++;
    if (ws_err !== 0) begin
      bad++;
      $display("FAIL %s ws_pattern: got %0d misplaced WS bits, required 0", name, ws_err);
    end
  endtask

  task automatic test_reset();
    bit found;
    do_reset(16'hFFFF);
    found = 1'b0;
    for (int i = 0; i < 4 * FW + 8; i++) begin
      @(posedge clk);
      #1;
      if (WS === 1'b1 && SCLK === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL reset_setup: got no WS=1 with SCLK=1, required one within a frame");
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (SCLK !== 1'b0) begin bad++; $display("FAIL reset_sclk: got %b, required 0", SCLK); end
    total++;
    if (WS !== 1'b0) begin bad++; $display("FAIL reset_ws: got %b, required 0", WS); end
    total++;
    if (SD !== 1'b0) begin bad++; $display("FAIL reset_sd: got %b, required 0", SD); end
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b, required 0", ready); end
    repeat (2) @(posedge clk);
    #2 clear_state();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (ready !== 1'b0 || SCLK !== 1'b1) begin
      bad++;
      $display("FAIL reset_edge1: got ready=%b SCLK=%b, required ready=0 SCLK=1", ready, SCLK);
    end
    @(posedge clk);
    #1;
    total++;
    if (ready !== 1'b1 || SCLK !== 1'b0 || SD !== 1'b1) begin
      bad++;
      $display("FAIL reset_edge2: got ready=%b SCLK=%b SD=%b, required 1 0 1", ready, SCLK, SD);
    end
    @(posedge clk);
    #1;
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready_width: got %b, required 0", ready); end
  endtask

  task automatic test_a55a();
    bit ok;
    do_reset(16'hA55A);
    wait_ready(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL a55a_ready: got no ready, required a pulse");
    end
    exp_q.push_back(16'hA55A);
    check_words("a55a");
  endtask

  task automatic test_back_to_back();
    do_reset(FW'($urandom));
    stream("handshake", 64);
    check_words("handshake");
    total++;
    if (rdy_width_err !== 0 || rdy_gap_err !== 0) begin
      bad++;
      $display("FAIL handshake_ready_timing: got width_err=%0d gap_err=%0d, required 0 0",
               rdy_width_err, rdy_gap_err);
    end
  endtask

  task automatic test_mid_reset();
    logic [FW-1:0] fresh;
    do_reset(FW'($urandom));
    stream("pre_reset", 20);
    check_words("pre_reset");
    repeat (7) @(posedge clk);
    fresh = FW'($urandom);
    do_reset(fresh);
    stream("post_reset", 10);
    total++;
    if (exp_q.size() == 0 || exp_q[0] !== fresh) begin
      bad++;
      $display("FAIL post_reset_first_capture: got %h, required %h",
               (exp_q.size() != 0) ? exp_q[0] : '0, fresh);
    end
    check_words("post_reset");
  endtask

  task automatic test_hold_ff00();
    bit ok;
    do_reset(16'hFF00);
    for (int i = 0; i < 3; i++) begin
      wait_ready(ok);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL hold_ready%0d: got no ready, required a pulse", i);
      end
      exp_q.push_back(16'hFF00);
    end
    check_words("hold_ff00");
    total++;
    if (rdy_width_err !== 0 || rdy_gap_err !== 0) begin
      bad++;
      $display("FAIL hold_ready_timing: got width_err=%0d gap_err=%0d, required 0 0",
               rdy_width_err, rdy_gap_err);
    end
  endtask

  initial begin
    test_reset();
    test_a55a();
    test_back_to_back();
    test_mid_reset();
    test_hold_ff00();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
